// File: rtl/copro_pkg.sv
// Shared types and constants for the nibble-sort co-processor host sequencer.
package copro_pkg;

  localparam int COPRO_WORD_W   = 32;
  localparam int COPRO_DATA_W   = 64;
  localparam int COPRO_SORT_CYC = 16;
  localparam int COPRO_CTRL_LAT = 23;

  typedef enum logic [2:0] {
    IDLE,
    PSH_HI,
    PSH_LO,
    STRT,
    WAIT,
    POP_HI,
    POP_LO,
    RSP
  } copro_st_t;

endpackage

// File: rtl/copro_ctrl_if.sv
// Command/response port and co-processor strobes of copro_ctrl.
// master is the sequencer side; slave is the host bridge plus co-processor side.
interface copro_ctrl_if;
  import copro_pkg::*;

  logic                    cmd_vld;
  logic                    cmd_rdy;
  logic [COPRO_DATA_W-1:0] cmd_data;
  logic                    rsp_vld;
  logic                    rsp_rdy;
  logic [COPRO_DATA_W-1:0] rsp_data;
  logic                    rsp_err;
  logic                    start;
  logic                    ready;
  logic                    dpsh;
  logic [COPRO_WORD_W-1:0] dinp;
  logic                    dpop;
  logic [COPRO_WORD_W-1:0] dout;

  modport master (
    input  cmd_vld, cmd_data, rsp_rdy, ready, dout,
    output cmd_rdy, rsp_vld, rsp_data, rsp_err, start, dpsh, dinp, dpop
  );

  modport slave (
    output cmd_vld, cmd_data, rsp_rdy, ready, dout,
    input  cmd_rdy, rsp_vld, rsp_data, rsp_err, start, dpsh, dinp, dpop
  );

endinterface

// File: rtl/copro_ctrl.sv
// Host-side sequencer: push operand, start, wait for ready, pop result, respond.
// Optional WAIT timeout enabled by defining COPRO_CTRL_TMO_EN.
module copro_ctrl
  import copro_pkg::*;
#(
  parameter int TMO_CYC = 64
) (
  input logic          ck,
  input logic          rb,
  copro_ctrl_if.master bus
);

  if (TMO_CYC <= COPRO_SORT_CYC || TMO_CYC > 255) begin : g_tmo_range
    $error("copro_ctrl: TMO_CYC must lie in 17..255");
  end

  copro_st_t               r_state;
  logic [COPRO_WORD_W-1:0] r_op_lo;
  logic                    r_cmd_rdy;
  logic                    r_rsp_vld;
  logic [COPRO_DATA_W-1:0] r_rsp_data;
  logic                    r_start;
  logic                    r_dpsh;
  logic [COPRO_WORD_W-1:0] r_dinp;
  logic                    r_dpop;

`ifdef COPRO_CTRL_TMO_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
  logic [7:0] r_tmo_cnt;
  logic       r_rsp_err;
  assign bus.rsp_err = r_rsp_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  // Outputs are registered: each branch loads the values of the state it enters.
  always_ff @(posedge ck or negedge rb) begin
    if (!rb) begin
      r_state    <= IDLE;
      r_op_lo    <= '0;
      r_cmd_rdy  <= 1'b1;
      r_rsp_vld  <= 1'b0;
      r_rsp_data <= '0;
      r_start    <= 1'b0;
      r_dpsh     <= 1'b0;
      r_dinp     <= '0;
      r_dpop     <= 1'b0;
`ifdef COPRO_CTRL_TMO_EN
      r_tmo_cnt  <= '0;
      r_rsp_err  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking throughout, so every branch sees the pre-edge state
      // and these strobe defaults are simply overridden by the branch below.
      r_start <= 1'b0;
      r_dpsh  <= 1'b0;
      r_dpop  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cmd_vld) begin
            r_op_lo   <= bus.cmd_data[COPRO_WORD_W-1:0];
            r_dinp    <= bus.cmd_data[COPRO_DATA_W-1:COPRO_WORD_W];
            r_dpsh    <= 1'b1;
            r_cmd_rdy <= 1'b0;
`ifdef COPRO_CTRL_TMO_EN
            r_rsp_err <= 1'b0;
`endif
            r_state   <= PSH_HI;
          end
        end
        // The co-processor shifts left on push, so the low word goes second.
        PSH_HI: begin
          r_dinp  <= r_op_lo;
          r_dpsh  <= 1'b1;
          r_state <= PSH_LO;
        end
        PSH_LO: begin
          r_start <= 1'b1;
          r_state <= STRT;
        end
        STRT: begin
`ifdef COPRO_CTRL_TMO_EN
          r_tmo_cnt <= '0;
`endif
          r_state <= WAIT;
        end
        WAIT: begin
          if (bus.ready) begin
            r_dpop  <= 1'b1;
            r_state <= POP_HI;
          end
`ifdef COPRO_CTRL_TMO_EN
          else if (r_tmo_cnt == TMO_LAST) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_rsp_vld  <= 1'b1;
            r_state    <= RSP;
          end
          r_tmo_cnt <= r_tmo_cnt + 8'd1;
`endif
        end
        // Two rotating pops leave the co-processor register as it was.
        POP_HI: begin
          r_rsp_data[COPRO_DATA_W-1:COPRO_WORD_W] <= bus.dout;
          r_dpop  <= 1'b1;
          r_state <= POP_LO;
        end
        POP_LO: begin
          r_rsp_data[COPRO_WORD_W-1:0] <= bus.dout;
          r_rsp_vld <= 1'b1;
          r_state   <= RSP;
        end
        RSP: begin
          if (bus.rsp_rdy) begin
            r_rsp_vld <= 1'b0;
            r_cmd_rdy <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_rsp_vld <= 1'b0;
          r_cmd_rdy <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_rdy  = r_cmd_rdy;
  assign bus.rsp_vld  = r_rsp_vld;
  assign bus.rsp_data = r_rsp_data;
  assign bus.start    = r_start;
  assign bus.dpsh     = r_dpsh;
  assign bus.dinp     = r_dinp;
  assign bus.dpop     = r_dpop;

endmodule
